// File: rtl/mor1kx_spr_bus_master.sv
// ---------------------------------------------------------------------------
// mor1kx_spr_bus_master
//
// SPR bus initiator. Turns single mtspr/mfspr requests from the execute stage
// into SPR bus accesses toward the responders (tick timer, PIC, caches, ...).
// The access is held until a responder acks, then read data is returned.
// An access that is never acked ends in a bus-error response once it has
// been held for TIMEOUT_CYCLES cycles. Only one access is outstanding.
//
// Parameters
//   TIMEOUT_CYCLES  cycles an unacked access is held before erroring (1..255)
//
// Ports
//   clk            clock, all state changes on the rising edge
//   rst_n          synchronous active-low reset
//   req_valid_i    request present
//   req_ready_o    master can accept a request (idle)
//   req_we_i       1 = write (mtspr), 0 = read (mfspr)
//   req_addr_i     SPR address {group[15:11], offset[10:0]}
//   req_dat_i      write data
//   rsp_valid_o    one-cycle response strobe
//   rsp_dat_o      read data; 0 for writes and on error
//   rsp_err_o      access timed out; qualified by rsp_valid_o
//   spr_access_o   SPR bus access strobe
//   spr_we_o       SPR bus write enable
//   spr_addr_o     SPR bus address
//   spr_dat_o      SPR bus write data
//   spr_bus_ack_i  OR of all responder acks
//   spr_dat_i      OR of all responder read data
// ---------------------------------------------------------------------------
module mor1kx_spr_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [15:0] req_addr_i,
    input  logic [31:0] req_dat_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        spr_access_o,
    output logic        spr_we_o,
    output logic [15:0] spr_addr_o,
    output logic [31:0] spr_dat_o,
    input  logic        spr_bus_ack_i,
    input  logic [31:0] spr_dat_i
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Value of the counter in the final ACCESS cycle before a timeout.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             we_q,      we_d;
    logic [15:0]      addr_q,    addr_d;
    logic [31:0]      wdat_q,    wdat_d;
    logic [31:0]      rsp_dat_q, rsp_dat_d;
    logic             rsp_err_q, rsp_err_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdat_q    <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdat_q    <= wdat_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdat_d    = wdat_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    wdat_d  = req_dat_i;
                    cnt_d   = '0;
                    state_d = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                // An ack in the last allowed cycle still counts as success.
                if (spr_bus_ack_i) begin
                    rsp_err_d = 1'b0;
                    rsp_dat_d = we_q ? 32'h0 : spr_dat_i;
                    state_d   = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_err_d = 1'b1;
                    rsp_dat_d = 32'h0;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_ready_o  = (state_q == ST_IDLE);
    assign spr_access_o = (state_q == ST_ACCESS);
    assign rsp_valid_o  = (state_q == ST_RESP);
    assign rsp_dat_o    = rsp_dat_q;
    assign rsp_err_o    = rsp_err_q;
    assign spr_we_o     = we_q;
    assign spr_addr_o   = addr_q;
    assign spr_dat_o    = wdat_q;

endmodule

// File: tb/tb_mor1kx_spr_bus_master.sv
// ---------------------------------------------------------------------------
// tb_mor1kx_spr_bus_master
//
// Scoreboard bench for the SPR bus master. The stimulus side issues requests
// and decides how the simulated responder behaves for each access (ack delay
// and read data, or no ack at all). From that decision the expected response
// is derived directly: success with data when the ack falls inside the
// timeout window, otherwise an error after TIMEOUT_CYCLES access cycles.
// A monitor watches the SPR bus and response port and compares independently.
// ---------------------------------------------------------------------------
module tb_mor1kx_spr_bus_master;

    localparam int T = 16;

    logic        clk;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [15:0] req_addr_i;
    logic [31:0] req_dat_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        spr_access_o;
    logic        spr_we_o;
    logic [15:0] spr_addr_o;
    logic [31:0] spr_dat_o;
    logic        spr_bus_ack_i;
    logic [31:0] spr_dat_i;

    mor1kx_spr_bus_master #(.TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_addr_i   (req_addr_i),
        .req_dat_i    (req_dat_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_dat_o    (rsp_dat_o),
        .rsp_err_o    (rsp_err_o),
        .spr_access_o (spr_access_o),
        .spr_we_o     (spr_we_o),
        .spr_addr_o   (spr_addr_o),
        .spr_dat_o    (spr_dat_o),
        .spr_bus_ack_i(spr_bus_ack_i),
        .spr_dat_i    (spr_dat_i)
    );

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdat;
        logic        err;
        logic [31:0] rdat;
        int          len;
        int          acceptCycle;
    } exp_t;

    exp_t        expQ[$];
    int          checkCount = 0;
    int          passCount  = 0;
    int          cycle      = 0;
    int          plannedDelay = -1;
    logic [31:0] plannedData  = 32'h0;
    bit          strayAck     = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cycle);
        else
            passCount++;
    endtask

    // Simulated responder: acks in the planned ACCESS cycle (0-based), drives
    // junk read data otherwise, and optionally a stray ack outside accesses.
    initial begin : responder
        int respCycle;
        respCycle     = 0;
        spr_bus_ack_i = 1'b0;
        spr_dat_i     = 32'h0;
        forever begin
            @(negedge clk);
            if (spr_access_o === 1'b1) begin
                spr_bus_ack_i = (respCycle == plannedDelay);
                spr_dat_i     = spr_bus_ack_i ? plannedData : $urandom;
                respCycle++;
            end else begin
                respCycle     = 0;
                spr_bus_ack_i = strayAck;
                spr_dat_i     = $urandom;
            end
        end
    end

    // Monitor: checks bus fields against the front expectation on the first
    // access cycle, tracks stability and length, and scores each response.
    initial begin : monitor
        int          accLen;
        bit          unstable;
        logic        firstWe;
        logic [15:0] firstAddr;
        logic [31:0] firstDat;
        exp_t        e;
        accLen   = 0;
        unstable = 1'b0;
        firstWe  = 1'b0;
        firstAddr = '0;
        firstDat  = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                accLen   = 0;
                unstable = 1'b0;
            end else begin
                if (spr_access_o === 1'b1) begin
                    if (accLen == 0) begin
                        firstWe   = spr_we_o;
                        firstAddr = spr_addr_o;
                        firstDat  = spr_dat_o;
                        checkOutput("req_ready_in_access", {31'h0, req_ready_o}, 32'h0);
                        if (expQ.size() == 0) begin
                            checkOutput("unexpected_access", 32'h1, 32'h0);
                        end else begin
                            checkOutput("spr_we", {31'h0, spr_we_o}, {31'h0, expQ[0].we});
                            checkOutput("spr_addr", {16'h0, spr_addr_o}, {16'h0, expQ[0].addr});
                            checkOutput("spr_dat", spr_dat_o, expQ[0].wdat);
                        end
                    end else if (spr_we_o !== firstWe || spr_addr_o !== firstAddr ||
                                 spr_dat_o !== firstDat) begin
                        unstable = 1'b1;
                    end
                    accLen++;
                end
                if (rsp_valid_o === 1'b1) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_rsp", 32'h1, 32'h0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("rsp_err", {31'h0, rsp_err_o}, {31'h0, e.err});
                        checkOutput("rsp_dat", rsp_dat_o, e.rdat);
                        checkOutput("access_len", accLen, e.len);
                        checkOutput("bus_stable", {31'h0, unstable}, 32'h0);
                        checkOutput("rsp_latency", cycle, e.acceptCycle + e.len);
                        checkOutput("spr_access_in_rsp", {31'h0, spr_access_o}, 32'h0);
                    end
                    accLen   = 0;
                    unstable = 1'b0;
                end
            end
        end
    end

    // Issues one request and records its expected outcome. delay < 0 means
    // the responder never acks.
    task automatic applyStimulus(input logic we, input logic [15:0] addr,
                                 input logic [31:0] dat, input int delay,
                                 input logic [31:0] ackDat, input bit holdValid);
        exp_t e;
        int   waited;
        @(negedge clk);
        req_we_i    = we;
        req_addr_i  = addr;
        req_dat_i   = dat;
        req_valid_i = 1'b1;
        waited = 0;
        while (req_ready_o !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (req_ready_o !== 1'b1) begin
            checkOutput("req_ready_timeout", {31'h0, req_ready_o}, 32'h1);
            req_valid_i = 1'b0;
            return;
        end
        plannedDelay  = delay;
        plannedData   = ackDat;
        e.we          = we;
        e.addr        = addr;
        e.wdat        = dat;
        e.err         = !(delay >= 0 && delay < T);
        e.rdat        = (e.err || we) ? 32'h0 : ackDat;
        e.len         = e.err ? T : delay + 1;
        e.acceptCycle = cycle + 1;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        if (!holdValid) req_valid_i = 1'b0;
    endtask

    task automatic waitDrain();
        int waited;
        waited = 0;
        while (expQ.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("drain", expQ.size(), 0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req_ready"}, {31'h0, req_ready_o}, 32'h1);
        checkOutput({tag, "_spr_access"}, {31'h0, spr_access_o}, 32'h0);
        checkOutput({tag, "_rsp_valid"}, {31'h0, rsp_valid_o}, 32'h0);
        checkOutput({tag, "_rsp_err"}, {31'h0, rsp_err_o}, 32'h0);
        checkOutput({tag, "_rsp_dat"}, rsp_dat_o, 32'h0);
        checkOutput({tag, "_spr_we"}, {31'h0, spr_we_o}, 32'h0);
        checkOutput({tag, "_spr_addr"}, {16'h0, spr_addr_o}, 32'h0);
        checkOutput({tag, "_spr_dat"}, spr_dat_o, 32'h0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        rst_n       = 1'b0;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_addr_i  = '0;
        req_dat_i   = '0;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed: write with immediate ack");
        applyStimulus(1'b1, 16'h5000, 32'hC000_0010, 0, 32'hDEAD_BEEF, 1'b0);
        $display("[TB] directed: read acked after 3 cycles");
        applyStimulus(1'b0, 16'h5001, 32'h0000_0000, 3, 32'h1234_5678, 1'b0);
        $display("[TB] directed: read never acked");
        applyStimulus(1'b0, 16'h5002, 32'h1111_2222, -1, 32'h0, 1'b0);
        $display("[TB] directed: ack in last access cycle");
        applyStimulus(1'b0, 16'h5003, 32'h0, T - 1, 32'hA5A5_A5A5, 1'b0);
        waitDrain();

        $display("[TB] directed: reset during second access cycle");
        applyStimulus(1'b0, 16'h2800, 32'h7777_0000, -1, 32'h0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        expQ.delete();
        @(posedge clk);
        #1;
        checkResetOutputs("midreset");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 16'h2801, 32'h0, 1, 32'h0BAD_F00D, 1'b0);
        waitDrain();

        $display("[TB] directed: held req_valid and stray ack");
        strayAck = 1'b1;
        applyStimulus(1'b1, 16'h4800, 32'hCAFE_0001, 2, 32'hFFFF_FFFF, 1'b1);
        applyStimulus(1'b0, 16'h4801, 32'hCAFE_0002, 0, 32'h0000_ABCD, 1'b0);
        waitDrain();
        repeat (3) @(negedge clk);
        strayAck = 1'b0;

        $display("[TB] randomized transactions");
        for (int i = 0; i < 40; i++) begin
            int delay;
            case ($urandom_range(0, 5))
                0:       delay = 0;
                1:       delay = $urandom_range(1, 4);
                2:       delay = T - 1;
                3:       delay = T;
                4:       delay = -1;
                default: delay = $urandom_range(0, T + 3);
            endcase
            strayAck = 1'($urandom_range(0, 1));
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), $urandom, delay,
                          $urandom, (i < 39) ? 1'($urandom_range(0, 1)) : 1'b0);
        end
        waitDrain();
        strayAck = 1'b0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
